// File: rtl/ex_muldiv_pkg.sv
// Core-wide M-extension defines shared by the EX-stage multiply/divide unit:
// funct3 codes, MULDIV state encodings and register-address width.
`timescale 1ns/1ps
package ex_muldiv_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step
// per cycle on a shared 64-bit register, result returned as a one-cycle write-back.
`timescale 1ns/1ps
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic [WIDTH-1:0]      rs1_data_i,
  input  logic [WIDTH-1:0]      rs2_data_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  stall_o,
  output logic [REG_ADDR_W-1:0] reg_waddr_o,
  output logic [WIDTH-1:0]      reg_wdata_o,
  output logic                  reg_wen_o
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  md_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [2:0]            op_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  neg_q, rem_neg_q;
  logic [WIDTH-1:0]      opnd_q;
  logic [2*WIDTH-1:0]    acc_q;

  logic             a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, fast_res;
  logic             div_zero, div_ovf, fast, accept;

  always_comb begin
    // NOTE: defaults first, so no path through the case leaves a signal unassigned (no latch).
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (op_i)
      F3_MUL, F3_MULH, F3_DIV, F3_REM: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      F3_MULHSU: a_signed = 1'b1;
      default: ;
    endcase
  end

  assign a_neg = a_signed & rs1_data_i[WIDTH-1];
  assign b_neg = b_signed & rs2_data_i[WIDTH-1];
  assign a_mag = a_neg ? -rs1_data_i : rs1_data_i;
  assign b_mag = b_neg ? -rs2_data_i : rs2_data_i;

  // Divide-by-zero and INT_MIN/-1 resolve without iterating.
  assign div_zero = op_i[2] & (rs2_data_i == '0);
  assign div_ovf  = op_i[2] & ~op_i[0] & (rs1_data_i == INT_MIN) & (rs2_data_i == '1);
  assign fast     = div_zero | div_ovf;
  assign fast_res = div_zero ? (op_i[1] ? rs1_data_i : '1)
                             : (op_i[1] ? '0 : INT_MIN);

  assign accept  = start_i & ~flush_i & (state_q != MD_CALC);
  assign stall_o = (state_q == MD_CALC) | (accept & ~fast);

  logic [WIDTH:0]     mul_sum, rem_shift;
  logic [WIDTH-1:0]   rem_diff, quot, rem, calc_res;
  logic               q_bit;
  logic [2*WIDTH-1:0] acc_nxt, prod;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    rem_shift = acc_q[2*WIDTH-1:WIDTH-1];
    // Only the low bits of the difference matter: it is kept only when it fits.
    rem_diff  = rem_shift[WIDTH-1:0] - opnd_q;
    q_bit     = (rem_shift >= {1'b0, opnd_q});
    if (op_q[2]) begin
      acc_nxt = {(q_bit ? rem_diff : rem_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], q_bit};
    end else begin
      acc_nxt = {mul_sum, acc_q[WIDTH-1:1]};
    end
    prod = neg_q ? -acc_nxt : acc_nxt;
    quot = neg_q ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
    rem  = rem_neg_q ? -acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[2*WIDTH-1:WIDTH];
    if (op_q[2]) begin
      calc_res = op_q[1] ? rem : quot;
    end else if (op_q == F3_MUL) begin
      calc_res = prod[WIDTH-1:0];
    end else begin
      calc_res = prod[2*WIDTH-1:WIDTH];
    end
  end

  logic                  wb_load;
  logic [WIDTH-1:0]      wb_data;
  logic [REG_ADDR_W-1:0] wb_addr;

  always_comb begin
    state_d = state_q;
    wb_load = 1'b0;
    wb_data = calc_res;
    wb_addr = rd_q;
    case (state_q)
      MD_CALC: begin
        if (flush_i) begin
          state_d = MD_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = MD_DONE;
          wb_load = 1'b1;
        end
      end
      default: begin
        // IDLE and DONE both accept a new instruction; an unused encoding recovers to IDLE.
        state_d = MD_IDLE;
        if (accept) begin
          if (fast) begin
            state_d = MD_DONE;
            wb_load = 1'b1;
            wb_data = fast_res;
            wb_addr = rd_addr_i;
          end else begin
            state_d = MD_CALC;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
    end else begin
      // NOTE: non-blocking for all clocked state so every flop samples pre-edge values.
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
    end else if (accept) begin
      cnt_q     <= '0;
      op_q      <= op_i;
      rd_q      <= rd_addr_i;
      neg_q     <= a_neg ^ b_neg;
      rem_neg_q <= a_neg;
      opnd_q    <= op_i[2] ? b_mag : a_mag;
      acc_q     <= {{WIDTH{1'b0}}, (op_i[2] ? a_mag : b_mag)};
    end else if (state_q == MD_CALC) begin
      cnt_q <= cnt_q + 1'b1;
      acc_q <= acc_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_o      <= 1'b0;
      reg_wen_o   <= 1'b0;
      reg_waddr_o <= '0;
      reg_wdata_o <= '0;
    end else begin
      busy_o    <= (state_d == MD_CALC);
      reg_wen_o <= wb_load & (wb_addr != '0);
      if (wb_load) begin
        reg_waddr_o <= wb_addr;
        reg_wdata_o <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed corner cases plus random operations
// compared against a plain-arithmetic RV32M reference model.
`timescale 1ns/1ps
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = '0;
  logic [31:0] rs1_data_i = '0;
  logic [31:0] rs2_data_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic        flush_i = 1'b0;
  logic        busy_o, stall_o, reg_wen_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o;

  int vectors = 0;
  int miscompares = 0;

  ex_muldiv #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .op_i       (op_i),
    .rs1_data_i (rs1_data_i),
    .rs2_data_i (rs2_data_i),
    .rd_addr_i  (rd_addr_i),
    .flush_i    (flush_i),
    .busy_o     (busy_o),
    .stall_o    (stall_o),
    .reg_waddr_o(reg_waddr_o),
    .reg_wdata_o(reg_wdata_o),
    .reg_wen_o  (reg_wen_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    logic [31:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    res = '0;
    case (op)
      3'd0: begin p = 64'(sa * sb); res = p[31:0]; end
      3'd1: begin p = 64'(sa * sb); res = p[63:32]; end
      3'd2: begin p = 64'(sa * ub); res = p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; res = p[63:32]; end
      3'd4: begin
        if (b == 0) res = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = 32'h8000_0000;
        else begin p = 64'(sa / sb); res = p[31:0]; end
      end
      3'd5: begin
        if (b == 0) res = 32'hFFFF_FFFF;
        else begin p = 64'(ua / ub); res = p[31:0]; end
      end
      3'd6: begin
        if (b == 0) res = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = 32'd0;
        else begin p = 64'(sa % sb); res = p[31:0]; end
      end
      default: begin
        if (b == 0) res = a;
        else begin p = 64'(ua % ub); res = p[31:0]; end
      end
    endcase
    return res;
  endfunction

  function automatic bit is_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Caller sits at a falling edge with the unit idle; that cycle is cycle 0.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
    bit          fast;
    int          lat, pulses, bad;
    logic [31:0] data;
    logic [4:0]  addr;
    fast = is_fast(op, a, b);
    start_i = 1'b1; op_i = op; rs1_data_i = a; rs2_data_i = b; rd_addr_i = rd;
    #1 check({tag, "/stall_c0"}, 32'(stall_o), 32'(!fast));
    @(posedge clk); #1 start_i = 1'b0;
    lat = -1; pulses = 0; bad = 0; data = '0; addr = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (reg_wen_o) begin
        pulses++;
        if (lat < 0) begin lat = k; data = reg_wdata_o; addr = reg_waddr_o; end
      end
      if (busy_o !== (!fast && k <= 32)) bad++;
      if (stall_o !== (!fast && k <= 32)) bad++;
    end
    check({tag, "/busy_stall"}, 32'(bad), 32'd0);
    if (rd == 0) begin
      check({tag, "/no_wb"}, 32'(pulses), 32'd0);
    end else begin
      check({tag, "/pulses"}, 32'(pulses), 32'd1);
      check({tag, "/latency"}, 32'(lat), fast ? 32'd1 : 32'd33);
      check({tag, "/wdata"}, data, ref_model(op, a, b));
      check({tag, "/waddr"}, 32'(addr), 32'(rd));
    end
  endtask

  task automatic wait_wb(input string tag, input logic [31:0] exp, output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (reg_wen_o) begin
        lat = k;
        check({tag, "/wdata"}, reg_wdata_o, exp);
        break;
      end
    end
  endtask

  initial begin
    int lat, pulses, bad;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [4:0]  rd;

    repeat (2) @(negedge clk);
    check("rst/busy", 32'(busy_o), 32'd0);
    check("rst/wen", 32'(reg_wen_o), 32'd0);
    check("rst/wdata", reg_wdata_o, 32'd0);
    check("rst/stall", 32'(stall_o), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("mul_7xm3", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
    run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7);
    run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd8);
    run_op("divu_by0", 3'd5, 32'd100, 32'd0, 5'd9);
    run_op("remu_by0", 3'd7, 32'd100, 32'd0, 5'd10);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
    run_op("mul_rd0", 3'd0, 32'd9, 32'd9, 5'd0);

    // Back-to-back: REM issued in the DONE cycle of DIV.
    start_i = 1'b1; op_i = 3'd4; rs1_data_i = 32'hFFFF_FFF9; rs2_data_i = 32'd2; rd_addr_i = 5'd13;
    @(posedge clk); #1 start_i = 1'b0;
    wait_wb("div_m7_2", 32'hFFFF_FFFD, lat);
    check("div_m7_2/latency", 32'(lat), 32'd33);
    start_i = 1'b1; op_i = 3'd6; rd_addr_i = 5'd14;
    #1 check("b2b/stall_in_done", 32'(stall_o), 32'd1);
    @(posedge clk); #1 start_i = 1'b0;
    wait_wb("rem_m7_2", 32'hFFFF_FFFF, lat);
    check("b2b/gap", 32'(lat), 32'd33);
    check("b2b/waddr", 32'(reg_waddr_o), 32'd14);
    @(negedge clk);

    // Flush in CALC cycle 10.
    start_i = 1'b1; op_i = 3'd0; rs1_data_i = 32'd5; rs2_data_i = 32'd6; rd_addr_i = 5'd15;
    @(posedge clk); #1 start_i = 1'b0;
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk); #1 flush_i = 1'b0;
    @(negedge clk);
    check("flush/busy", 32'(busy_o), 32'd0);
    check("flush/stall", 32'(stall_o), 32'd0);
    pulses = 0;
    for (int k = 0; k < 35; k++) begin
      @(negedge clk);
      if (reg_wen_o) pulses++;
    end
    check("flush/no_wb", 32'(pulses), 32'd0);

    // start together with flush in IDLE is dropped.
    start_i = 1'b1; flush_i = 1'b1; op_i = 3'd0; rs1_data_i = 32'd2; rs2_data_i = 32'd2;
    rd_addr_i = 5'd3;
    #1 check("startflush/stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1 begin start_i = 1'b0; flush_i = 1'b0; end
    pulses = 0; bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (reg_wen_o) pulses++;
      if (busy_o) bad++;
    end
    check("startflush/no_wb", 32'(pulses), 32'd0);
    check("startflush/no_busy", 32'(bad), 32'd0);

    for (int n = 0; n < 60; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      rd = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op($sformatf("rnd%0d_op%0d", n, op), op, a, b, rd);
    end

    // Asynchronous reset in CALC cycle 20.
    start_i = 1'b1; op_i = 3'd0; rs1_data_i = 32'h0001_2345; rs2_data_i = 32'h777;
    rd_addr_i = 5'd11;
    @(posedge clk); #1 start_i = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst/busy", 32'(busy_o), 32'd0);
    check("arst/wen", 32'(reg_wen_o), 32'd0);
    check("arst/waddr", 32'(reg_waddr_o), 32'd0);
    check("arst/wdata", reg_wdata_o, 32'd0);
    check("arst/stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (reg_wen_o) pulses++;
    end
    check("arst/no_wb", 32'(pulses), 32'd0);
    run_op("mul_3x4_after_rst", 3'd0, 32'd3, 32'd4, 5'd7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative RV32M multiply/divide unit in the EX stage of the 5-stage core. It takes rs1/rs2 operand values read by the register file during ID. It computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over multiple cycles, stalling the pipeline while busy. It returns the result through a one-cycle write-back pulse (address/data/enable) into the register-file write path, whose same-cycle bypass makes the value visible to ID immediately.

## Interface
- WIDTH, 32, datapath width; only 32 is supported.
- clk  in  1  core clock; one clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- start_i  in  1  M-extension instruction valid in EX this cycle.
- op_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_data_i  in  WIDTH  operand A (dividend / multiplicand).
- rs2_data_i  in  WIDTH  operand B (divisor / multiplier).
- rd_addr_i  in  5  destination register.
- flush_i  in  1  abort the in-flight operation (branch/exception).
- busy_o  out  1  high while in CALC.
- stall_o  out  1  combinational pipeline stall request.
- reg_waddr_o  out  5  write-back address.
- reg_wdata_o  out  WIDTH  write-back data.
- reg_wen_o  out  1  write-back enable, single-cycle pulse.

## Operation
- States: IDLE, CALC, DONE. Reset → IDLE. All outputs except stall_o are registered.
- Start is accepted in IDLE or DONE when start_i=1 and flush_i=0. Operands, op and rd are latched, and sign magnitudes are taken:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU/DIVU/REMU: both unsigned.
- Fast path (no CALC):
  - Divisor zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → rs1.
  - Signed overflow (DIV/REM of 0x80000000 by 0xFFFFFFFF): DIV → 0x80000000; REM → 0.
  - Either case goes directly to DONE.
- Otherwise → CALC with a 5-bit counter starting at 0. One iteration per cycle, 32 iterations:
  - Multiply: shift-add on magnitudes into a 64-bit accumulator.
  - Divide: restoring division with a 33-bit partial remainder.
- Counter 31 → DONE. Result selection:
  - Product is negated if the operand signs differ (signed interpretations only).
  - MUL takes the low 32 bits; MULH* take the high 32 bits.
  - Quotient is negated if signs differ.
  - Remainder takes the sign of the dividend.
- DONE: reg_wen_o=1 for exactly this cycle, with reg_waddr_o/reg_wdata_o valid.
  - rd=0 → reg_wen_o stays 0; the operation still runs.
  - Next state: IDLE, or a new CALC/DONE if a start is accepted in DONE.
- Outside DONE: reg_wen_o=0; reg_waddr_o/reg_wdata_o hold their last values.
- start_i in CALC is ignored; the pipeline is stalled, so the instruction is held upstream.
- flush_i:
  - Has priority over start_i.
  - In CALC → IDLE next cycle, no write-back.
  - In DONE, the already-issued pulse is not retracted.
- stall_o = (CALC) OR (start_i AND NOT flush_i AND not fast path AND state≠CALC).
- Asynchronous reset mid-operation: state IDLE, counter 0; busy_o, reg_wen_o, reg_waddr_o, reg_wdata_o all 0; no write-back after release.

## Timing
- Start accepted at cycle 0 (normal path):
  - CALC in cycles 1–32; busy_o high in those cycles.
  - DONE and reg_wen_o in cycle 33.
  - stall_o high in cycles 0–32 and low in cycle 33, so the instruction leaves EX as its result is written.
- Fast path: stall_o low in cycle 0; DONE/reg_wen_o in cycle 1.
- Back-to-back: a start in cycle 33 (DONE) gives its next reg_wen_o in cycle 66; no bubble cycle.
- Write-back pulse goes to the write-back arbitration. The register file's same-cycle bypass forwards reg_wdata_o to ID in cycle 33.

## Structure
- Shared package (core-wide defines file):
  - M-extension funct3 constants.
  - MULDIV state encodings.
  - Register-address width (5).
- Single module, no sub-module: the FSM, counter and shared shift datapath (accumulator / partial remainder) stay together. Multiply and divide reuse one 64-bit shift register.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), rd=5, start cycle 0 → reg_wen_o only in cycle 33, waddr 5, wdata 0xFFFFFFEB; stall_o high cycles 0–32.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF; MULH 0x80000000×0x80000000 → 0x40000000.
- DIVU 100/0 → 0xFFFFFFFF and REMU 100/0 → 100, each with reg_wen_o in cycle 1 and stall_o never high; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
- DIV −7/2 → 0xFFFFFFFD and REM −7/2 → 0xFFFFFFFF; back-to-back start in DONE cycle → second reg_wen_o exactly 33 cycles later.
- flush_i at CALC cycle 10 → no reg_wen_o, busy_o 0 next cycle; start_i+flush_i together in IDLE → not accepted; rd=0 MUL → reg_wen_o never asserts.
- rst_n low in CALC cycle 20 → all outputs 0 immediately (asynchronous); after release, no write-back, and a new MUL 3×4 → 12 at +33.
